// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: sprite OAM DMA, halts the CPU and copies page $XX00-$XXFF to OAMDATA
// Ports: CPU_CLK/CPU_RESET clock and sync active-high reset;
//   cpu_addr/cpu_wdata/cpu_rw_n snooped CPU bus cycle; dma_rdata bus read data;
//   cpu_halt CPU stall; dma_bus_en bus mux select; dma_addr/dma_rw_n/dma_wdata DMA bus cycle;
//   dma_done one-cycle pulse after the last OAMDATA write
module oam_dma_ctrl #(
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [15:0] OAMDATA_ADDR = 16'h2004,
  parameter int          XFER_LEN     = 256
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RESET,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rw_n,
  input  logic [7:0]  dma_rdata,
  output logic        cpu_halt,
  output logic        dma_bus_en,
  output logic [15:0] dma_addr,
  output logic        dma_rw_n,
  output logic [7:0]  dma_wdata,
  output logic        dma_done
);
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
  state_t r_state, w_nxt;
  logic r_cyc_odd, w_trig, w_last;
  logic [7:0] r_page, r_idx, r_data, w_page, w_idx, w_data;
  always_comb begin
    w_trig = r_state == IDLE && cpu_addr == TRIGGER_ADDR && !cpu_rw_n;
    w_last = r_state == WRITE && r_idx == 8'(XFER_LEN - 1);
    // HALT with cyc_odd=1 means the next cycle is even, so reads can start immediately
    w_nxt  = r_state == IDLE  ? (w_trig ? HALT : IDLE) :
             r_state == HALT  ? (r_cyc_odd ? READ : ALIGN) :
             r_state == ALIGN ? READ :
             r_state == READ  ? WRITE :
             (w_last ? IDLE : READ);
    w_page = w_trig ? cpu_wdata : r_page;
    w_idx  = w_trig ? 8'h00 : (r_state == WRITE && !w_last) ? r_idx + 8'd1 : r_idx;
    w_data = r_state == READ ? dma_rdata : r_data;
  end
  // outputs are registered from the next state so they line up with r_state
  always_ff @(posedge CPU_CLK) begin
    if (CPU_RESET) begin
      r_state    <= IDLE;
      r_cyc_odd  <= 1'b0;
      r_page     <= 8'h00;
      r_idx      <= 8'h00;
      r_data     <= 8'h00;
      cpu_halt   <= 1'b0;
      dma_bus_en <= 1'b0;
      dma_addr   <= 16'h0000;
      dma_rw_n   <= 1'b1;
      dma_wdata  <= 8'h00;
      dma_done   <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_cyc_odd  <= ~r_cyc_odd;
      r_page     <= w_page;
      r_idx      <= w_idx;
      r_data     <= w_data;
      cpu_halt   <= w_nxt != IDLE;
      dma_bus_en <= w_nxt != IDLE;
      dma_addr   <= w_nxt == READ ? {w_page, w_idx} : w_nxt == WRITE ? OAMDATA_ADDR : 16'h0000;
      dma_rw_n   <= w_nxt != WRITE;
      dma_wdata  <= w_nxt == WRITE ? w_data : 8'h00;
      dma_done   <= w_last;
    end
  end
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: directed self-checking bench for oam_dma_ctrl
module tb_oam_dma_ctrl;
  logic CPU_CLK = 1'b0, CPU_RESET = 1'b1;
  logic [15:0] cpu_addr = 16'h0;
  logic [7:0] cpu_wdata = 8'h0;
  logic cpu_rw_n = 1'b1;
  logic [7:0] dma_rdata;
  logic cpu_halt, dma_bus_en, dma_rw_n, dma_done;
  logic [15:0] dma_addr;
  logic [7:0] dma_wdata;
  logic tb_odd = 1'b0;
  int n_chk = 0, n_fail = 0;
  oam_dma_ctrl dut (
    .CPU_CLK(CPU_CLK), .CPU_RESET(CPU_RESET), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rw_n(cpu_rw_n), .dma_rdata(dma_rdata), .cpu_halt(cpu_halt), .dma_bus_en(dma_bus_en),
    .dma_addr(dma_addr), .dma_rw_n(dma_rw_n), .dma_wdata(dma_wdata), .dma_done(dma_done)
  );
  always #5 CPU_CLK = ~CPU_CLK;
  always @(posedge CPU_CLK) tb_odd <= CPU_RESET ? 1'b0 : ~tb_odd;
  assign dma_rdata = dma_addr[7:0] ^ 8'hA5;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge CPU_CLK);
  endtask
  task automatic cpu_idle();
    cpu_addr = 16'h0000;
    cpu_rw_n = 1'b1;
    cpu_wdata = 8'h00;
  endtask
  task automatic trig(input logic [7:0] pg);
    cpu_addr = 16'h4014;
    cpu_rw_n = 1'b0;
    cpu_wdata = pg;
    step();
    cpu_idle();
  endtask
  task automatic wait_par(input logic b);
    if (tb_odd != b) step();
  endtask
  task automatic watch(input logic [7:0] pg, input logic odd, input int kill);
    int hn = 0, nr = 0, nw = 0, first = -1;
    int bad_rd = 0, bad_par = 0, bad_wr = 0, bad_en = 0, bad_done = 0;
    logic [15:0] last = 16'h0;
    for (int c = 0; c < 600 && cpu_halt; c++) begin
      hn++;
      if (!dma_bus_en) bad_en++;
      if (dma_done) bad_done++;
      if (hn == 50) begin
        cpu_addr = 16'h4014;
        cpu_rw_n = 1'b0;
        cpu_wdata = pg + 8'd1;
      end else cpu_idle();
      if (dma_rw_n && dma_addr != 16'h0) begin
        if (first < 0) first = hn;
        if (dma_addr != {pg, 8'(nr)}) bad_rd++;
        if (tb_odd) bad_par++;
        last = dma_addr;
        nr++;
      end else if (!dma_rw_n) begin
        if (dma_addr != 16'h2004 || dma_wdata != (8'(nw) ^ 8'hA5) || nw + 1 != nr) bad_wr++;
        nw++;
      end
      if (kill > 0 && nw == kill) break;
      step();
    end
    chk("first_read", first, odd ? 3 : 2);
    chk("read_addr", bad_rd, 0);
    chk("read_parity", bad_par, 0);
    chk("write_seq", bad_wr, 0);
    chk("bus_en", bad_en, 0);
    chk("early_done", bad_done, 0);
    if (kill > 0) begin
      CPU_RESET = 1'b1;
      cpu_idle();
      step();
      CPU_RESET = 1'b0;
      chk("writes_before_reset", nw, kill);
      chk("reset_halt", cpu_halt, 0);
      chk("reset_bus_en", dma_bus_en, 0);
      chk("reset_done", dma_done, 0);
      step();
      chk("reset_done2", dma_done, 0);
      chk("reset_rw", dma_rw_n, 1);
    end else begin
      chk("halt_len", hn, odd ? 514 : 513);
      chk("reads", nr, 256);
      chk("writes", nw, 256);
      chk("last_read", last, {pg, 8'hFF});
      chk("done", dma_done, 1);
      chk("idle_addr", dma_addr, 0);
    end
  endtask
  initial begin
    logic p;
    int h;
    cpu_idle();
    repeat (3) step();
    CPU_RESET = 1'b0;
    chk("rst_halt", cpu_halt, 0);
    chk("rst_bus_en", dma_bus_en, 0);
    chk("rst_addr", dma_addr, 0);
    chk("rst_rw", dma_rw_n, 1);
    chk("rst_wdata", dma_wdata, 0);
    chk("rst_done", dma_done, 0);
    h = 0;
    repeat (20) begin
      step();
      if (cpu_halt) h++;
    end
    chk("idle_20", h, 0);
    wait_par(1'b0);
    trig(8'h02);
    watch(8'h02, 1'b0, 0);
    step();
    chk("done_once", dma_done, 0);
    wait_par(1'b1);
    trig(8'h03);
    watch(8'h03, 1'b1, 0);
    step();
    wait_par(1'b0);
    trig(8'h05);
    watch(8'h05, 1'b0, 100);
    wait_par(1'b0);
    trig(8'h04);
    watch(8'h04, 1'b0, 0);
    p = tb_odd;
    trig(8'h06);
    watch(8'h06, p, 0);
    step();
    chk("b2b_done_once", dma_done, 0);
    cpu_addr = 16'h4014;
    cpu_rw_n = 1'b1;
    cpu_wdata = 8'h07;
    step();
    cpu_idle();
    step();
    chk("read_4014", cpu_halt, 0);
    cpu_addr = 16'h4015;
    cpu_rw_n = 1'b0;
    cpu_wdata = 8'h07;
    step();
    cpu_idle();
    step();
    chk("write_4015", cpu_halt, 0);
    CPU_RESET = 1'b1;
    cpu_addr = 16'h4014;
    cpu_rw_n = 1'b0;
    cpu_wdata = 8'h07;
    step();
    CPU_RESET = 1'b0;
    cpu_idle();
    chk("reset_trig", cpu_halt, 0);
    step();
    chk("reset_trig2", cpu_halt, 0);
    wait_par(1'b1);
    trig(8'hFF);
    watch(8'hFF, 1'b1, 0);
    step();
    chk("ff_idle_halt", cpu_halt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
